// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle datapath controller.
// Holds the FSM state encoding, the instruction opcodes, the ALU/operand-B
// encodings and the Moore output decode used by the controller FSM.
package ctrl_pkg;

    localparam int OPC_W = 11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_WB_LD    = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_WB_R     = 4'd8,
        S_BRANCH   = 4'd9,
        S_ERROR    = 4'd10
    } state_e;

    // Full 11-bit opcodes
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'h7C2;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'h7C0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'h458;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'h658;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'h450;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'h550;
    // Branch opcodes are identified by a prefix only: CBZ on opcode[10:3],
    // B on opcode[10:5] (the remaining bits belong to the immediate).
    localparam logic [7:0] OPC_CBZ = 8'hB4;
    localparam logic [5:0] OPC_B   = 6'h05;

    // ALU operation select
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_PASS_B = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    // ALU operand-B select
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    // Outputs that depend on the state alone (registered in the FSM).
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic       illegal_op;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    function automatic ctl_t moore_ctl(input state_e s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.mem_read  = 1'b1;
                c.iord      = 1'b0;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_b = SRCB_SEXT;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_WB_LD: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                c.pc_src    = 1'b1;
                c.alu_src_b = SRCB_SEXT_SH2;
                c.alu_op    = ALU_PASS_B;
            end
            S_ERROR: begin
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier for the multicycle controller.
// Ports: opcode (inst[31:21]) in; one-hot-ish class flags out
// (is_ld, is_st, is_r, is_cbz, is_b, is_illegal); exactly one is high.
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_ld,
    output logic             is_st,
    output logic             is_r,
    output logic             is_cbz,
    output logic             is_b,
    output logic             is_illegal
);

    assign is_ld  = (opcode == OPC_LDUR);
    assign is_st  = (opcode == OPC_STUR);
    assign is_r   = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                    (opcode == OPC_AND) || (opcode == OPC_ORR);
    assign is_cbz = (opcode[10:3] == OPC_CBZ);
    assign is_b   = (opcode[10:5] == OPC_B);

    assign is_illegal = ~(is_ld | is_st | is_r | is_cbz | is_b);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM (fetch/decode/execute/memory/writeback).
// Ports: clk, rst_n (async, active-low), opcode/zero/mem_ready in; memory,
// register-file, PC, ALU-select controls, sticky illegal_op and debug state out.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INST_SIZE = 32,
    parameter int ALU_OP_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INST_SIZE-22:0] opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 reg2loc,
    output logic                 mem_to_reg,
    output logic                 pc_src,
    output logic                 illegal_op,
    output logic [1:0]           alu_src_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [3:0]           state
);

    state_e state_q, state_d;
    ctl_t   ctl_q;
    // Instruction class captured in DECODE so later states do not depend on
    // the instruction register staying untouched.
    logic   st_q, st_d;
    logic   b_q,  b_d;

    logic is_ld, is_st, is_r, is_cbz, is_b, is_illegal;

    opcode_decoder u_dec (
        .opcode     (opcode),
        .is_ld      (is_ld),
        .is_st      (is_st),
        .is_r       (is_r),
        .is_cbz     (is_cbz),
        .is_b       (is_b),
        .is_illegal (is_illegal)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                st_d = is_st;
                b_d  = is_b;
                if (is_illegal)           state_d = S_ERROR;
                else if (is_ld || is_st)  state_d = S_MEM_ADDR;
                else if (is_r)            state_d = S_EXEC_R;
                else                      state_d = S_BRANCH;
            end
            S_MEM_ADDR: state_d = st_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_LD;
            S_WB_LD:    state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            // Unused encodings are treated as a fault.
            default:    state_d = S_ERROR;
        endcase
    end

    // State and the state-only outputs are registered together: the output
    // register is loaded with the decode of the next state, so it always
    // matches state_q with no combinational decode on the output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            st_q    <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= moore_ctl(state_d);
            st_q    <= st_d;
            b_q     <= b_d;
        end
    end

    // Handshake- and flag-qualified outputs must react within the cycle.
    assign ir_write = (state_q == S_FETCH) && mem_ready;
    assign pc_write = ir_write || ((state_q == S_BRANCH) && (b_q || zero));
    // reg2loc selects Rt as the second read register while decoding STUR/CBZ.
    assign reg2loc  = (state_q == S_DECODE) && (is_st || is_cbz);

    assign mem_req    = ctl_q.mem_req;
    assign mem_read   = ctl_q.mem_read;
    assign mem_write  = ctl_q.mem_write;
    assign iord       = ctl_q.iord;
    assign reg_write  = ctl_q.reg_write;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign pc_src     = ctl_q.pc_src;
    assign illegal_op = ctl_q.illegal_op;
    assign alu_src_b  = ctl_q.alu_src_b;
    assign alu_op     = ALU_OP_W'(ctl_q.alu_op);
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Drives each instruction class cycle by cycle and compares state plus the
// full control vector against hand-written expected values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic        reg_write, reg2loc, mem_to_reg, pc_src, illegal_op;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [3:0]  state;

    multicycle_ctrl #(.INST_SIZE(32), .ALU_OP_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg2loc    (reg2loc),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req,mem_read,mem_write,iord}, {ir_write,pc_write},
    // {reg_write,reg2loc,mem_to_reg,pc_src}, illegal_op, alu_src_b, alu_op
    logic [14:0] outs;
    assign outs = {mem_req, mem_read, mem_write, iord, ir_write, pc_write,
                   reg_write, reg2loc, mem_to_reg, pc_src, illegal_op,
                   alu_src_b, alu_op};

    localparam logic [14:0] O_ZERO   = 15'd0;
    localparam logic [14:0] O_FRDY   = {4'b1100, 2'b11, 4'b0000, 1'b0, 2'b01, 2'b00};
    localparam logic [14:0] O_FWAIT  = {4'b1100, 2'b00, 4'b0000, 1'b0, 2'b01, 2'b00};
    localparam logic [14:0] O_DEC    = {4'b0000, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00};
    localparam logic [14:0] O_DEC_R2 = {4'b0000, 2'b00, 4'b0100, 1'b0, 2'b00, 2'b00};
    localparam logic [14:0] O_MA     = {4'b0000, 2'b00, 4'b0000, 1'b0, 2'b10, 2'b00};
    localparam logic [14:0] O_MRD    = {4'b1101, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00};
    localparam logic [14:0] O_WBLD   = {4'b0000, 2'b00, 4'b1010, 1'b0, 2'b00, 2'b00};
    localparam logic [14:0] O_MWR    = {4'b1011, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00};
    localparam logic [14:0] O_EX     = {4'b0000, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b10};
    localparam logic [14:0] O_WBR    = {4'b0000, 2'b00, 4'b1000, 1'b0, 2'b00, 2'b00};
    localparam logic [14:0] O_BR_T   = {4'b0000, 2'b01, 4'b0001, 1'b0, 2'b11, 2'b01};
    localparam logic [14:0] O_BR_NT  = {4'b0000, 2'b00, 4'b0001, 1'b0, 2'b11, 2'b01};
    localparam logic [14:0] O_ERR    = {4'b0000, 2'b00, 4'b0000, 1'b1, 2'b00, 2'b00};

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DEC = 4'd2,
                           ST_MA = 4'd3, ST_MRD = 4'd4, ST_WBLD = 4'd5,
                           ST_MWR = 4'd6, ST_EX = 4'd7, ST_WBR = 4'd8,
                           ST_BR = 4'd9, ST_ERR = 4'd10;

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, apply this cycle's handshake/flag inputs, then check.
    task automatic step(input string tag, input logic mr, input logic zr,
                        input logic [3:0] es, input logic [14:0] eo);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = zr;
        #1;
        chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
        chk({tag, ".outs"}, {17'd0, outs}, {17'd0, eo});
    endtask

    // Mutual-exclusion invariants checked every cycle, reported once at the end.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write) viol++;
            if (reg_write && pc_write) viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] rops [3];
        rops[0] = 11'h658;
        rops[1] = 11'h450;
        rops[2] = 11'h550;

        rst_n     = 1'b0;
        opcode    = 11'h7C2;   // LDUR 0xF84402C9
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #2;
        chk("rst.state", {28'd0, state}, {28'd0, ST_IDLE});
        chk("rst.outs", {17'd0, outs}, {17'd0, O_ZERO});
        @(negedge clk);
        rst_n = 1'b1;

        // LDUR, zero-wait memory: 5 cycles
        step("ld_f",  1, 0, ST_FETCH, O_FRDY);
        step("ld_d",  1, 0, ST_DEC,   O_DEC);
        step("ld_ma", 1, 0, ST_MA,    O_MA);
        step("ld_rd", 1, 0, ST_MRD,   O_MRD);
        step("ld_wb", 1, 0, ST_WBLD,  O_WBLD);

        // ADD 0x8B09026A, two FETCH wait cycles; stray mem_ready elsewhere ignored
        opcode = 11'h458;
        step("add_f0", 0, 0, ST_FETCH, O_FWAIT);
        step("add_f1", 0, 0, ST_FETCH, O_FWAIT);
        step("add_f2", 1, 0, ST_FETCH, O_FRDY);
        step("add_d",  0, 0, ST_DEC,   O_DEC);
        step("add_ex", 1, 0, ST_EX,    O_EX);
        step("add_wb", 0, 0, ST_WBR,   O_WBR);

        // CBZ 0xB4FFFF6B not taken, then taken
        opcode = 11'h5A7;
        step("cbz0_f",  1, 0, ST_FETCH, O_FRDY);
        step("cbz0_d",  1, 0, ST_DEC,   O_DEC_R2);
        step("cbz0_br", 1, 0, ST_BR,    O_BR_NT);
        step("cbz1_f",  1, 0, ST_FETCH, O_FRDY);
        step("cbz1_d",  1, 0, ST_DEC,   O_DEC_R2);
        step("cbz1_br", 1, 1, ST_BR,    O_BR_T);

        // B: pc_write regardless of zero
        opcode = 11'h0A0;
        step("b_f",  1, 0, ST_FETCH, O_FRDY);
        step("b_d",  1, 0, ST_DEC,   O_DEC);
        step("b_br", 1, 0, ST_BR,    O_BR_T);

        // STUR 0xF80602CB with one write wait cycle
        opcode = 11'h7C0;
        step("st_f",  1, 0, ST_FETCH, O_FRDY);
        step("st_d",  1, 0, ST_DEC,   O_DEC_R2);
        step("st_ma", 1, 0, ST_MA,    O_MA);
        step("st_w0", 0, 0, ST_MWR,   O_MWR);
        step("st_w1", 1, 0, ST_MWR,   O_MWR);

        // Remaining R-type opcodes: SUB, AND, ORR
        for (int i = 0; i < 3; i++) begin
            opcode = rops[i];
            step("r_f",  1, 0, ST_FETCH, O_FRDY);
            step("r_d",  1, 0, ST_DEC,   O_DEC);
            step("r_ex", 1, 0, ST_EX,    O_EX);
            step("r_wb", 1, 0, ST_WBR,   O_WBR);
        end

        // Illegal opcode 0x000: ERROR is sticky
        opcode = 11'h000;
        step("il_f", 1, 0, ST_FETCH, O_FRDY);
        step("il_d", 1, 0, ST_DEC,   O_DEC);
        step("il_e", 1, 0, ST_ERR,   O_ERR);
        for (int i = 0; i < 10; i++) begin
            step("il_hold", logic'(i % 2), logic'(i % 3 == 0), ST_ERR, O_ERR);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("il_rst.state", {28'd0, state}, {28'd0, ST_IDLE});
        chk("il_rst.outs", {17'd0, outs}, {17'd0, O_ZERO});
        @(negedge clk);
        opcode = 11'h7C2;
        rst_n  = 1'b1;
        step("il_rel_f", 1, 0, ST_FETCH, O_FRDY);

        // Reset during a MEM_RD wait
        step("r36_d",  1, 0, ST_DEC, O_DEC);
        step("r36_ma", 0, 0, ST_MA,  O_MA);
        step("r36_w0", 0, 0, ST_MRD, O_MRD);
        step("r36_w1", 0, 0, ST_MRD, O_MRD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r36_rst.state", {28'd0, state}, {28'd0, ST_IDLE});
        chk("r36_rst.outs", {17'd0, outs}, {17'd0, O_ZERO});
        @(negedge clk);
        rst_n = 1'b1;
        step("r36_f0", 0, 0, ST_FETCH, O_FWAIT);
        step("r36_f1", 0, 0, ST_FETCH, O_FWAIT);

        // Near-miss of STUR/LDUR is still illegal
        opcode = 11'h7C1;
        step("nm_f", 1, 0, ST_FETCH, O_FRDY);
        step("nm_d", 1, 0, ST_DEC,   O_DEC);
        step("nm_e", 1, 0, ST_ERR,   O_ERR);

        chk("excl", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: INST_SIZE, 32, instruction width; opcode is inst[31:21].
REQ-002 Parameter: ALU_OP_W, 2, width of alu_op.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: opcode  input  11  inst[31:21] from the instruction register.
REQ-006 Port: zero  input  1  ALU zero flag, valid in BRANCH.
REQ-007 Port: mem_ready  input  1  memory handshake, access completes in the cycle it is high.
REQ-008 Ports (output, 1 bit each):
- mem_req: memory access request.
- mem_read: memory read.
- mem_write: memory write.
- iord: 0 = PC address, 1 = ALU address.
- ir_write, pc_write, reg_write, reg2loc, mem_to_reg, pc_src.
- illegal_op: sticky error flag.
REQ-009 Ports (output): alu_src_b  2  (00 reg, 01 const 4, 10 sign_extend output, 11 sign_extend<<2); alu_op  ALU_OP_W  (00 add, 01 pass-B, 10 funct); state  4  current state for debug.

Function
REQ-010 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, WB_LD, MEM_WR, EXEC_R, WB_R, BRANCH, ERROR.
REQ-011 The FSM is Moore-style; outputs decode from state, except pc_write/ir_write (gated by mem_ready) and pc_write in BRANCH (gated by zero).
REQ-012 IDLE: all outputs 0; goes to FETCH unconditionally.
REQ-013 FETCH drives:
- mem_req=1, mem_read=1, iord=0, alu_src_b=01, alu_op=00.
- ir_write and pc_write high only in the mem_ready cycle.
- Stays in FETCH while mem_ready=0.
REQ-014 DECODE: reg2loc=1 for STUR/CBZ, else 0. Next state:
- LDUR (7C2) or STUR (7C0) -> MEM_ADDR.
- ADD (458), SUB (658), AND (450), ORR (550) -> EXEC_R.
- CBZ (opcode[10:3]=B4) or B (opcode[10:5]=05) -> BRANCH.
- Anything else -> ERROR.
REQ-015 MEM_ADDR: alu_src_b=10, alu_op=00; goes to MEM_RD for LDUR, MEM_WR for STUR.
REQ-016 MEM_RD: mem_req=1, mem_read=1, iord=1; holds until mem_ready, then goes to WB_LD.
REQ-017 WB_LD: reg_write=1, mem_to_reg=1; goes to FETCH.
REQ-018 MEM_WR: mem_req=1, mem_write=1, iord=1; holds until mem_ready, then goes to FETCH.
REQ-019 EXEC_R: alu_src_b=00, alu_op=10; goes to WB_R.
REQ-020 WB_R: reg_write=1, mem_to_reg=0; goes to FETCH.
REQ-021 BRANCH: pc_src=1, alu_src_b=11, alu_op=01.
- pc_write=1 for B.
- pc_write=zero for CBZ.
- Goes to FETCH.
REQ-022 ERROR: illegal_op=1, all other outputs 0; remains there until reset.
REQ-023 Latency with zero-wait memory (mem_ready already high):
- R-type 4 cycles, LDUR 5, STUR 4, B/CBZ 3.
- Each wait cycle adds exactly one cycle.
REQ-024 mem_ready high outside FETCH/MEM_RD/MEM_WR is ignored.
REQ-025 mem_read and mem_write are never high in the same cycle.
REQ-026 reg_write and pc_write are never high in the same cycle.

Reset
REQ-027 rst_n low immediately forces state=IDLE and all outputs to 0, including illegal_op, from any state, including mid-memory-wait.
REQ-028 After rst_n deasserts, the first rising edge moves IDLE -> FETCH.

Structure
REQ-029 The state enum, opcode constants (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B) and alu_op encodings shall live in the shared package ctrl_pkg.
REQ-030 Opcode classification shall be one combinational sub-module, opcode_decoder, with:
- input: opcode;
- outputs: is_ld, is_st, is_r, is_cbz, is_b, is_illegal.

Verification
REQ-031 LDUR 0xF84402C9, mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, WB_LD; reg_write=1 and mem_to_reg=1 only in WB_LD.
REQ-032 ADD 0x8B09026A with mem_ready low for 2 FETCH cycles -> ir_write pulses once, in the 3rd FETCH cycle; WB_R occurs 5 cycles after FETCH entry.
REQ-033 CBZ 0xB4FFFF6B with zero=0 -> pc_write=0 in BRANCH; repeat with zero=1 -> pc_write=1 and pc_src=1.
REQ-034 STUR 0xF80602CB -> mem_write=1, iord=1 in MEM_WR; reg_write never asserted.
REQ-035 Opcode 0x000 -> ERROR with illegal_op=1, held for 10 cycles; rst_n pulse low -> illegal_op=0, state IDLE then FETCH.
REQ-036 rst_n asserted during a MEM_RD wait (mem_ready=0) -> outputs 0 in the same cycle; no reg_write after release.
